// File: rtl/cdc_handshake_tx_pkg.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx_pkg
// Shared definitions for the transmit end of the 4-phase req/ack CDC handshake:
//   - state_e          : FSM state encoding (2 bits)
//   - SYNC_STAGES_MIN  : smallest allowed synchroniser depth
//   - cnt_width()      : width of a counter able to hold 0..max_val
// -----------------------------------------------------------------------------
package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ_WAIT = 2'b01,
    ACK_WAIT = 2'b10
  } state_e;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// N-stage single-bit synchroniser, every flop asynchronously cleared to 0.
// Depths below SYNC_STAGES_MIN are raised to that minimum.
// Ports:
//   clk    : destination-domain clock
//   resetn : asynchronous active-low reset
//   d      : asynchronous input bit
//   q      : synchronised output, STAGES cycles after d
// -----------------------------------------------------------------------------
module sync_chain
  import cdc_handshake_tx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its neighbour held before this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ff <= '0;
    else         ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
// Source (transmit) end of a 4-phase req/ack clock-domain-crossing handshake.
// A word accepted on the valid/ready side is held on tx_data while tx_req is a
// level request; the far-domain tx_ack is synchronised before use.
//
// Optional feature: define CDC_TX_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYCLES cycles (tx_err pulses, no tx_done).
//
// Ports:
//   clk     : source-domain clock
//   resetn  : asynchronous active-low reset
//   s_valid : upstream word valid
//   s_ready : block can accept a word this cycle
//   s_data  : upstream word
//   tx_req  : level request to far domain (flop output)
//   tx_data : registered word, stable while tx_req=1 and during ACK_WAIT
//   tx_ack  : asynchronous acknowledge from far domain
//   tx_done : one-cycle pulse when a transfer completes
//   tx_err  : one-cycle pulse on timeout abort (0 without the feature)
// -----------------------------------------------------------------------------
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  tx_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ack,
  output logic                  tx_done,
  output logic                  tx_err
);

  state_e state;
  logic   ack_s;
  logic   accept;
  logic   timeout;
  logic   aborted;

  // tx_ack goes nowhere except into this chain.
  sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (tx_ack),
    .q      (ack_s)
  );

  // A stale acknowledge (far side still high) holds off the next transfer.
  assign s_ready = (state == IDLE) && !ack_s;
  assign accept  = s_valid && s_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt;

  // The counter holds the number of REQ_WAIT cycles already spent; the abort
  // fires on the edge where it would reach TIMEOUT_CYCLES.
  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
      aborted  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      if (accept) begin
        wait_cnt <= '0;
        aborted  <= 1'b0;
      end else if (state == REQ_WAIT && !ack_s) begin
        if (timeout) begin
          tx_err  <= 1'b1;
          aborted <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign aborted            = 1'b0;
  assign tx_err             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tx_req  <= 1'b0;
      tx_data <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data <= s_data;
            tx_req  <= 1'b1;
            state   <= REQ_WAIT;
          end
        end
        // A falling ack_s here without a prior rise is simply not acted upon.
        REQ_WAIT: begin
          if (ack_s || timeout) begin
            tx_req <= 1'b0;
            state  <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (!ack_s) begin
            tx_done <= !aborted;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_tx
// Self-checking bench for cdc_handshake_tx. A transaction-level model predicts
// every output each cycle; a small far-side responder drives tx_ack.
// Honours CDC_TX_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic          clk     = 1'b0;
  logic          resetn  = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          tx_ack  = 1'b0;
  logic          s_ready, tx_req, tx_done, tx_err;
  logic [DW-1:0] tx_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_ack  (tx_ack),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  // ---------------- reference model (transaction level) ----------------
  bit            samp [SYNC];   // tx_ack as seen on the last SYNC edges, [0] newest
  bit            m_busy, m_req, m_abort, m_done, m_err, m_acc;
  logic [DW-1:0] m_data;
  int            m_wait;
  int            cyc;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] got_q[$];
  int            done_cnt, err_cnt;
  int            ack_rise_edge, req_fall_edge, acc_edge;
  bit            prev_req, prev_ack;
  logic [DW-1:0] prev_data;

  // far-side responder
  bit far_en;
  int far_up, far_dn, far_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (samp[i]) samp[i] = 1'b0;
    m_busy = 0; m_req = 0; m_abort = 0; m_done = 0; m_err = 0; m_acc = 0;
    m_data = '0; m_wait = 0; prev_req = 0;
    sent_q.delete();
  endtask

  // Called exactly at the rising edge, while inputs still hold their pre-edge values.
  task automatic model_edge();
    bit acks;
    cyc++;
    m_done = 0; m_err = 0; m_acc = 0;
    if (tx_ack && !prev_ack) ack_rise_edge = cyc;
    prev_ack = tx_ack;
    if (!resetn) begin
      model_reset();
      return;
    end
    acks = samp[SYNC-1];
    if (!m_busy) begin
      if (s_valid && !acks) begin
        m_busy = 1; m_req = 1; m_data = s_data; m_wait = 0; m_abort = 0;
        m_acc = 1; acc_edge = cyc;
        sent_q.push_back(s_data);
      end
    end else if (m_req) begin
      if (acks) m_req = 0;
      else begin
        m_wait++;
`ifdef CDC_TX_TIMEOUT_EN
        if (m_wait == TO) begin
          m_req = 0; m_err = 1; m_abort = 1;
        end
`endif
      end
    end else if (!acks) begin
      m_busy = 0;
      m_done = !m_abort;
      if (m_abort) void'(sent_q.pop_front());
    end
    for (int i = SYNC - 1; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = tx_ack;
  endtask

  task automatic compare();
    check("s_ready", s_ready, !m_busy && !samp[SYNC-1]);
    check("tx_req",  tx_req,  m_req);
    check("tx_data", tx_data, m_data);
    check("tx_done", tx_done, m_done);
    check("tx_err",  tx_err,  m_err);
    if (prev_req) check("data_stable", tx_data, prev_data);
    if (prev_req && !tx_req) req_fall_edge = cyc;
    if (tx_done) begin
      done_cnt++;
      got_q.push_back(tx_data);
      check("sb_depth", sent_q.size(), 1);
      if (sent_q.size() > 0) check("sb_order", tx_data, sent_q.pop_front());
    end
    if (tx_err) err_cnt++;
    prev_req  = tx_req;
    prev_data = tx_data;
  endtask

  task automatic far_side();
    if (!far_en) return;
    if (tx_req != tx_ack) begin
      far_cnt++;
      if (far_cnt >= (tx_req ? far_up : far_dn)) begin
        tx_ack  = tx_req;
        far_cnt = 0;
      end
    end else begin
      far_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    far_side();
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 100);
    check(tag, tx_req, 1);
  endtask

  task automatic run_until_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int stale_edge;
  int a_edge;
  int req_hi;

  initial begin
    model_reset();
    cyc = 0; done_cnt = 0; err_cnt = 0;
    ack_rise_edge = -1; req_fall_edge = -1; acc_edge = -1;
    far_en = 0; far_up = 3; far_dn = 3; far_cnt = 0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_req",   tx_req,  0);
    check("rst_data",  tx_data, 0);
    check("rst_done",  tx_done, 0);
    check("rst_err",   tx_err,  0);
    check("rst_ready", s_ready, 1);
    resetn = 1'b1;
    tick();

    // ---- basic transfer ----
    far_en = 1; far_up = 3; far_dn = 3;
    done_cnt = 0;
    s_valid = 1; s_data = 8'hA5;
    tick();
    check("basic_ready_low", s_ready, 0);
    check("basic_req",       tx_req,  1);
    check("basic_data",      tx_data, 8'hA5);
    s_valid = 0;
    run_until_done(1, 60, "basic_done");
    check("basic_req_fall", req_fall_edge - ack_rise_edge, SYNC);
    tick();
    check("basic_one_done", done_cnt, 1);
    check("basic_ready_after", s_ready, 1);

    // ---- back-to-back, s_valid held ----
    done_cnt = 0; got_q.delete();
    for (int w = 1; w <= 4; w++) begin
      s_valid = 1; s_data = 8'(w);
      wait_accept("b2b_accept");
    end
    s_valid = 0;
    run_until_done(4, 200, "b2b_done");
    check("b2b_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) check("b2b_order", got_q[i], i + 1);

    // ---- randomized traffic ----
    done_cnt = 0;
    for (int t = 0; t < 24; t++) begin
      far_up = $urandom_range(1, 4);
      far_dn = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) tick();
      s_valid = 1; s_data = 8'($urandom);
      wait_accept("rnd_accept");
      s_valid = 0;
    end
    run_until_done(24, 400, "rnd_done");

    // ---- stale ack at reset release ----
    far_en = 0; s_valid = 0;
    repeat (2) tick();
    resetn = 0; tx_ack = 1;
    repeat (2) tick();
    resetn = 1;
    // The chain restarts from 0, so the stale level takes SYNC edges to appear.
    repeat (SYNC) tick();
    s_valid = 1; s_data = 8'h3C;
    repeat (10 - SYNC) begin
      tick();
      check("stale_block", s_ready, 0);
    end
    tx_ack = 0;
    stale_edge = cyc + 1;
    wait_accept("stale_accept");
    check("stale_accept_edge", acc_edge - stale_edge, SYNC);
    s_valid = 0;
    done_cnt = 0; far_en = 1; far_up = 2; far_dn = 2;
    run_until_done(1, 60, "stale_done");

    // ---- reset mid-transfer ----
    far_up = 1; far_dn = 1;
    s_valid = 1; s_data = 8'h5A;
    wait_accept("mid_accept");
    s_valid = 0;
    while (!tx_ack && cyc - acc_edge < 20) tick();
    check("mid_in_req_wait", tx_req, 1);
    far_en = 0;           // far side keeps acking across the reset
    done_cnt = 0;
    #2 resetn = 0;
    #1;
    check("mid_rst_req",  tx_req,  0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_done", tx_done, 0);
    model_reset();
    repeat (2) tick();
    resetn = 1;
    repeat (SYNC) tick();
    s_valid = 1; s_data = 8'hC3;
    repeat (4) begin
      tick();
      check("mid_stale_block", tx_req, 0);
    end
    check("mid_no_done", done_cnt, 0);
    tx_ack = 0; far_en = 1;
    wait_accept("mid_reaccept");
    s_valid = 0;
    run_until_done(1, 60, "mid_done");
    check("mid_word", got_q[got_q.size()-1], 8'hC3);

    // ---- timeout behaviour (far side silent) ----
    far_en = 0; tx_ack = 0;
    repeat (2) tick();
    s_valid = 1; s_data = 8'h77;
    wait_accept("to_accept");
    s_valid = 0;
    a_edge = acc_edge; err_cnt = 0; done_cnt = 0; req_hi = 0; req_fall_edge = -1;
    repeat (100) begin
      tick();
      if (tx_req) req_hi++;
    end
`ifdef CDC_TX_TIMEOUT_EN
    check("to_req_drop", req_fall_edge - a_edge, TO);
    check("to_err_cnt",  err_cnt, 1);
    check("to_no_done",  done_cnt, 0);
    check("to_ready",    s_ready, 1);
`else
    check("nto_req_held", req_hi, 100);
    check("nto_err",      err_cnt, 0);
    far_en = 1; far_up = 2; far_dn = 2;
    run_until_done(1, 60, "nto_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-side (transmit) end of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts one data word per transfer on a valid/ready interface in its own clock domain.
- Holds the word stable on tx_data while driving a level request. Synchronises the far-domain acknowledge internally.
- Pairs with the existing destination-side synchroniser/receiver that samples tx_req/tx_data in the far clock domain.

Parameters:
- DATA_WIDTH, 8, width of the transferred word.
- SYNC_STAGES, 2, flops in the tx_ack synchroniser chain (minimum 2).
- TIMEOUT_CYCLES, 1024, REQ_WAIT cycles before abort; used only with CDC_TX_TIMEOUT_EN.

Ports:
- clk  input  1  source-domain clock, all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  DATA_WIDTH  upstream word.
- tx_req  output  1  level request to far domain, driven directly from a flop.
- tx_data  output  DATA_WIDTH  registered word; stable whenever tx_req=1.
- tx_ack  input  1  asynchronous acknowledge from far domain; only ever enters the synchroniser chain.
- tx_done  output  1  one-cycle pulse when a transfer completes.
- tx_err  output  1  one-cycle pulse on timeout abort; constant 0 without the macro.

Behaviour:
- Asynchronous reset, active low. While resetn=0:
  - state=IDLE.
  - tx_req=0, tx_data=0, tx_done=0, tx_err=0.
  - All sync flops cleared to 0.
  - Timeout counter cleared to 0.
- ack_s is tx_ack after SYNC_STAGES flops, giving SYNC_STAGES cycles of latency.
- s_ready = (state==IDLE) && !ack_s. This is combinational from registers, with no path from s_valid.
- States:
  - IDLE: on s_valid && s_ready at edge N:
    - tx_data<=s_data and tx_req<=1.
    - Both are visible after edge N; go to REQ_WAIT.
  - REQ_WAIT: tx_req held at 1 and tx_data frozen. When ack_s=1:
    - tx_req<=0; go to ACK_WAIT.
  - ACK_WAIT: when ack_s=0:
    - tx_done pulses for exactly one cycle; go to IDLE.
- tx_data changes only on accept and never changes while tx_req=1 or during ACK_WAIT.
- Minimum transfer period with an ideal far side: 2*SYNC_STAGES plus the far-side latency. Back-to-back acceptance is possible on the cycle after tx_done when ack_s=0.
- A stale ack_s=1 in IDLE (e.g. the far side came out of reset late) blocks acceptance until it clears; no transfer starts.
- A glitch where ack_s falls in REQ_WAIT without having risen is ignored; the block stays in REQ_WAIT.
- Reset mid-transfer:
  - tx_req drops asynchronously and the word is lost.
  - No tx_done is produced.
  - After reset the block waits for ack_s=0 before accepting.
- s_valid while s_ready=0: no effect. Upstream must hold s_valid and s_data until accepted.

Optional Feature:
- Macro: CDC_TX_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to REQ_WAIT and increments each REQ_WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with ack_s still 0: tx_req<=0, tx_err pulses one cycle, and the state goes to ACK_WAIT.
  - ACK_WAIT then exits normally without tx_done, once ack_s=0. tx_done and tx_err never pulse for the same transfer.
- Undefined:
  - No counter is present and tx_err is tied to 0.
  - REQ_WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, REQ_WAIT, ACK_WAIT) with a 2-bit encoding.
  - The SYNC_STAGES minimum constant (2).
- One sub-module, sync_chain: a parameterised N-stage, async-reset-to-0 single-bit synchroniser used for tx_ack. It is the generalised form of the existing 2-flop sync.

Test Plan:
- Basic transfer:
  - Stimulus: reset, then s_valid=1, s_data=8'hA5 at edge 0; far model raises tx_ack 3 cycles after tx_req and drops it 3 cycles after tx_req falls.
  - Required: s_ready=0 from edge 0; tx_req=1 and tx_data=8'hA5 after edge 0; tx_req falls 2 cycles after tx_ack rises; exactly one tx_done; s_ready=1 afterwards.
- Back-to-back:
  - Stimulus: s_valid held with words 8'h01 through 8'h04.
  - Required: four tx_done pulses; tx_data order 01,02,03,04; tx_data never changes while tx_req=1.
- Stale ack:
  - Stimulus: tx_ack=1 at reset release, deasserted 10 cycles later, with s_valid=1 throughout.
  - Required: s_ready=0 until 2 cycles after tx_ack falls; then the accept occurs.
- Reset mid-transfer:
  - Stimulus: assert resetn=0 during REQ_WAIT.
  - Required: tx_req=0 immediately with no clock; tx_data=0; no tx_done.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Stimulus: tx_ack tied to 0.
  - Required: tx_req drops 16 cycles after accept; one tx_err pulse; no tx_done; s_ready=1 on the next cycle.
- Timeout (macro undefined):
  - Stimulus: same as above.
  - Required: tx_req stays 1 for 100 cycles; tx_err stays 0.
